i2c_slave: RTL and testbench
============================

Name: i2c_slave

Overview:
- I2C target (slave) that sits on the same SCL/SDA bus as our I2C master.
- Oversamples SCL/SDA in the system clock domain and decodes START, STOP and repeated START.
- Matches a fixed 7-bit address and ACKs. Sets an 8-bit register pointer, then auto-increments it across multi-byte reads and writes.
- Connects to a register bank through a simple synchronous write/read strobe interface.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this target responds to.
- SYNC_STAGES, 2, synchronizer flops on SCL and SDA (minimum 2).

Ports:
- clk  input  1  system clock (50 MHz nominal, ≥20x SCL rate).
- rst_n  input  1  asynchronous active-low reset.
- SCL  input  1  bus clock from master.
- SDA  inout  1  bus data; driven 1'b0 when sda_oe=1, else 1'bz (open-drain).
- reg_addr  output  8  current register pointer.
- wr_en  output  1  one-clk pulse; write wr_data to reg_addr.
- wr_data  output  8  received data byte.
- rd_en  output  1  one-clk pulse; bank must present rd_data for reg_addr on the next clk.
- rd_data  input  8  read data, sampled 1 clk after rd_en.
- busy  output  1  high from address match to STOP or repeated START.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, sda_oe=0, reg_addr=0, wr_en=0, wr_data=0, rd_en=0, busy=0. Synchronizer flops reset to 1.
- Edge detect on synchronized signals. Latency from a pin edge to internal detection is SYNC_STAGES+1 clk.
- START: SDA falls while SCL high. Accepted in any state (repeated START), always goes to ADDR with bit count cleared. reg_addr is kept.
- STOP: SDA rises while SCL high. Accepted in any state, goes to IDLE; busy=0, sda_oe=0.
- Sampling and driving:
  - Data is sampled on SCL rising edge, MSB first.
  - The target changes sda_oe only on the clk after a detected SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address + R/W). After the 8th rise: on match go to ADDR_ACK; on mismatch go to WAIT_STOP (never drive).
  - ADDR_ACK: drive 0 for the 9th SCL period; busy=1. R/W=0 goes to REG; R/W=1 pulses rd_en then goes to RDATA.
  - REG: shift 8 bits, load reg_addr, go to REG_ACK (drive 0), then WDATA.
  - WDATA: shift 8 bits. On the 8th rise: wr_data=byte, then wr_en pulses once in the WDATA_ACK drive period. reg_addr increments after wr_en and wraps 8'hFF→8'h00. Then back to WDATA.
  - RDATA: load shift register from rd_data. On each SCL fall drive sda_oe=~bit (MSB first). After 8 bits release SDA and go to RDATA_ACK.
  - RDATA_ACK: sample master ACK on the 9th rise.
    - ACK (0): reg_addr increments (wrapping), rd_en pulses on the 9th fall, go to RDATA.
    - NACK (1): go to WAIT_STOP.
  - WAIT_STOP: released; only START or STOP leave it.
- Read pointer: rd_en in ADDR_ACK uses the current reg_addr. A write-pointer-then-repeated-START read returns the register just addressed.
- Bus aborts: STOP/START mid-byte discards the partial byte; no wr_en is issued.
- SCL falling edge ends every ACK drive period; SDA is released before the next data bit.
- wr_en and rd_en never both high; each is exactly 1 clk wide.

Optional Feature:
- Macro I2C_GLITCH_FILTER_EN.
- Defined: after synchronization, each of SCL/SDA is accepted only when 4 consecutive clk samples agree; otherwise the previous filtered value holds. Detection latency grows by 3 clk; pulses shorter than 4 clk are suppressed.
- Undefined: filter absent; the synchronized value is used directly.

Test Plan:
- Write burst: START, 0xA0, 0x10, 0x5A, 0x3C, STOP.
  - Expect ACK on all 4 bytes.
  - wr_en at reg_addr 0x10/data 0x5A, then 0x11/0x3C.
  - Final reg_addr=0x12; busy falls after STOP.
- Read with repeated START: START, 0xA0, 0x20, RSTART, 0xA1; bank returns 0xC3 for 0x20 and 0x81 for 0x21.
  - Master ACKs byte 1 and NACKs byte 2, then STOP.
  - SDA bits 11000011 then 10000001; rd_en pulses twice; WAIT_STOP then IDLE.
- Address mismatch: START, 0xA2, 0x10, 0xFF, STOP.
  - SDA never driven (NACK read as 1).
  - No wr_en or rd_en; busy stays 0.
- Pointer wrap: write pointer 0xFF then data 0x11, 0x22.
  - wr_en at 0xFF then 0x00; reg_addr ends at 0x01.
- Abort and reset: STOP after 4 bits of a data byte gives no wr_en and state IDLE. rst_n low during a read ACK period releases SDA immediately and sets all outputs to reset values.
- With I2C_GLITCH_FILTER_EN: 2-clk SDA low pulse while SCL high produces no START; a 6-clk pulse is detected as START.

Source files
------------

// File: rtl/i2c_slave.sv
`timescale 1ns/1ps
// i2c_slave: I2C target sharing the SCL/SDA bus with our I2C master.
// The bus is oversampled in the clk domain. The block decodes START, STOP and
// repeated START, and ACKs a fixed 7-bit address. The first byte written sets
// an 8-bit register pointer. The pointer then auto-increments across
// multi-byte reads and writes.
//
// Optional build macro: I2C_GLITCH_FILTER_EN. When it is defined, each
// synchronized line must hold the same value for 4 clk samples before the
// filtered value changes.
//
// Ports:
//   clk      in   system clock (>= 20x SCL rate)
//   rst_n    in   asynchronous active-low reset
//   SCL      in   bus clock from the master
//   SDA      io   bus data, open-drain (driven low or released)
//   reg_addr out  current register pointer
//   wr_en    out  1-clk pulse: write wr_data to reg_addr
//   wr_data  out  last received data byte
//   rd_en    out  1-clk pulse: bank presents rd_data for reg_addr next clk
//   rd_data  in   read data, sampled 1 clk after rd_en
//   busy     out  high from address match until STOP / repeated START
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] reg_addr,
  output logic       wr_en,
  output logic [7:0] wr_data,
  output logic       rd_en,
  input  logic [7:0] rd_data,
  output logic       busy
);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_REG       = 4'd3;
  localparam logic [3:0] ST_REG_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RDATA_ACK = 4'd8;
  localparam logic [3:0] ST_WAIT_STOP = 4'd9;

  // ---------------- input conditioning ----------------
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic scl_s, sda_s, scl_f, sda_f;
  logic scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;

  assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], SCL};
  assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], SDA};
  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
  logic [2:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic       scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;

  // Change only when the current sample and the 3 before it agree.
  always_comb begin
    scl_hist_d = {scl_hist_q[1:0], scl_s};
    sda_hist_d = {sda_hist_q[1:0], sda_s};
    scl_filt_d = scl_filt_q;
    sda_filt_d = sda_filt_q;
    if (&{scl_hist_q, scl_s})       scl_filt_d = 1'b1;
    else if (~|{scl_hist_q, scl_s}) scl_filt_d = 1'b0;
    if (&{sda_hist_q, sda_s})       sda_filt_d = 1'b1;
    else if (~|{sda_hist_q, sda_s}) sda_filt_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
    end
  end

  assign scl_f = scl_filt_d;
  assign sda_f = sda_filt_d;
`else
  assign scl_f = scl_s;
  assign sda_f = sda_s;
`endif

  assign scl_prev_d = scl_f;
  assign sda_prev_d = sda_f;

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f & ~scl_prev_q;
  assign scl_fall  = ~scl_f & scl_prev_q;
  // SCL must be high on both samples so an SCL edge is never read as START/STOP.
  assign start_det = scl_f & scl_prev_q & ~sda_f & sda_prev_q;
  assign stop_det  = scl_f & scl_prev_q & sda_f & ~sda_prev_q;

  // ---------------- protocol FSM ----------------
  logic [3:0] state_q, state_d, bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, reg_addr_q, reg_addr_d, wr_data_q, wr_data_d;
  logic       sda_oe_q, sda_oe_d, wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic       rd_load_q, rd_load_d, busy_q, busy_d, rw_q, rw_d;
  logic       drive_pend_q, drive_pend_d;
  logic [7:0] rx_byte;

  assign rx_byte = {shift_q[6:0], sda_f};

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    sda_oe_d     = sda_oe_q;
    reg_addr_d   = reg_addr_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    rd_load_d    = rd_en_q;     // bank data is valid the clk after rd_en
    busy_d       = busy_q;
    rw_d         = rw_q;
    drive_pend_d = drive_pend_q;

    // The pointer moves on the clk after the write strobe.
    if (wr_en_q) reg_addr_d = reg_addr_q + 8'd1;

    if (stop_det) begin
      state_d      = ST_IDLE;
      sda_oe_d     = 1'b0;
      busy_d       = 1'b0;
      bit_cnt_d    = 4'd0;
      drive_pend_d = 1'b0;
    end else if (start_det) begin
      state_d      = ST_ADDR;
      sda_oe_d     = 1'b0;
      busy_d       = 1'b0;
      bit_cnt_d    = 4'd0;
      drive_pend_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_REG, ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (state_q == ST_ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_d = ST_ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = ST_WAIT_STOP;
                end
              end else if (state_q == ST_REG) begin
                reg_addr_d = rx_byte;
                state_d    = ST_REG_ACK;
              end else begin
                wr_data_d = rx_byte;
                state_d   = ST_WDATA_ACK;
              end
            end
          end
        end
        // The first fall starts the ACK drive. The next fall ends it.
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
              if (state_q == ST_WDATA_ACK) wr_en_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              if (state_q == ST_ADDR_ACK && rw_q) begin
                rd_en_d      = 1'b1;
                drive_pend_d = 1'b1;
                state_d      = ST_RDATA;
              end else if (state_q == ST_ADDR_ACK) begin
                state_d = ST_REG;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end
        // The first bit is driven once the bank data has landed.
        // Later bits are driven on each SCL fall.
        ST_RDATA: begin
          if (rd_load_q) begin
            shift_d = rd_data;
          end else if (drive_pend_q && !rd_en_q) begin
            sda_oe_d     = ~shift_q[7];
            shift_d      = {shift_q[6:0], 1'b0};
            bit_cnt_d    = 4'd1;
            drive_pend_d = 1'b0;
          end else if (scl_fall && !drive_pend_q) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = ST_RDATA_ACK;
            end else begin
              sda_oe_d  = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise && sda_f) begin
            state_d = ST_WAIT_STOP;
          end else if (scl_fall) begin
            reg_addr_d   = reg_addr_q + 8'd1;
            rd_en_d      = 1'b1;
            drive_pend_d = 1'b1;
            bit_cnt_d    = 4'd0;
            state_d      = ST_RDATA;
          end
        end
        ST_IDLE, ST_WAIT_STOP: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q   <= '1;
      sda_sync_q   <= '1;
      scl_prev_q   <= 1'b1;
      sda_prev_q   <= 1'b1;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'd0;
      sda_oe_q     <= 1'b0;
      reg_addr_q   <= 8'd0;
      wr_data_q    <= 8'd0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_load_q    <= 1'b0;
      busy_q       <= 1'b0;
      rw_q         <= 1'b0;
      drive_pend_q <= 1'b0;
    end else begin
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      scl_prev_q   <= scl_prev_d;
      sda_prev_q   <= sda_prev_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      sda_oe_q     <= sda_oe_d;
      reg_addr_q   <= reg_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      rd_load_q    <= rd_load_d;
      busy_q       <= busy_d;
      rw_q         <= rw_d;
      drive_pend_q <= drive_pend_d;
    end
  end

  assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
  assign reg_addr = reg_addr_q;
  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign rd_en    = rd_en_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
`timescale 1ns/1ps
// tb_i2c_slave: table-driven bench for i2c_slave.
// A behavioural master drives the bus, and a registered-read bank model
// serves reads. A monitor logs every wr_en/rd_en strobe. Each table row
// drives one bus action or checks one expected result.
module tb_i2c_slave;

  localparam int Q = 80;  // quarter SCL period in ns (32 clk per bit)

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;  // 1 = master releases SDA
  wire        sda_bus;
  logic [7:0] reg_addr, wr_data;
  logic [7:0] rd_data = 8'd0;
  logic       wr_en, rd_en, busy;

  assign sda_bus = m_sda ? 1'bz : 1'b0;
  pullup (sda_bus);

  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SCL      (scl),
    .SDA      (sda_bus),
    .reg_addr (reg_addr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  // Register bank with registered read
  logic [7:0] mem [256];
  always @(posedge clk) if (rd_en) rd_data <= mem[reg_addr];

  // Strobe monitor
  typedef struct packed { logic [7:0] a; logic [7:0] d; } wev_t;
  wev_t       wq[$];
  logic [7:0] rq[$];
  int         overlap_cnt = 0;
  int         wide_cnt = 0;
  logic       wr_en_p = 1'b0, rd_en_p = 1'b0;
  always @(posedge clk) begin
    if (wr_en) wq.push_back({reg_addr, wr_data});
    if (rd_en) rq.push_back(reg_addr);
    if (wr_en && rd_en) overlap_cnt++;
    if ((wr_en && wr_en_p) || (rd_en && rd_en_p)) wide_cnt++;
    wr_en_p <= wr_en;
    rd_en_p <= rd_en;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Bus primitives. Each one starts and ends with SCL low, except after STOP.
  task automatic send_bit(input logic b, output logic rb);
    m_sda = b; #Q; scl = 1'b1; #Q; rb = sda_bus; #Q; scl = 1'b0; #Q;
  endtask
  task automatic send_start();
    m_sda = 1'b1; #Q; scl = 1'b1; #Q; m_sda = 1'b0; #Q; scl = 1'b0; #Q;
  endtask
  task automatic send_stop();
    m_sda = 1'b0; #Q; scl = 1'b1; #Q; m_sda = 1'b1; #Q; #Q;
  endtask
  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic rb;
    for (int i = 7; i >= 0; i--) send_bit(b[i], rb);
    send_bit(1'b1, ack);
  endtask
  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic rb;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, rb);
      d[i] = rb;
    end
    send_bit(mack, rb);
  endtask

  // Table records
  typedef enum int {OP_START, OP_STOP, OP_WR, OP_RD, OP_CHK, OP_WEV, OP_REV, OP_NOEV} op_e;
  // OP_WR: a=byte, c=expected ACK bit. OP_RD: c=master ACK, b=expected byte.
  // OP_CHK: a=reg_addr, c=busy. OP_WEV: a=addr, b=data. OP_REV: a=addr.
  typedef struct { op_e op; logic [7:0] a; logic [7:0] b; logic c; string nm; } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(op_e op, logic [7:0] a, logic [7:0] b, logic c, string nm);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.c = c; v.nm = nm;
    return v;
  endfunction

  logic       ack;
  logic [7:0] rdb;
  wev_t       we;
  logic [7:0] re;
  logic       rb;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'hC3;
    mem[8'h21] = 8'h81;

    // Write burst
    vecs.push_back(mk(OP_START, 8'h00, 8'h00, 1'b0, "w_start"));
    vecs.push_back(mk(OP_WR,    8'hA0, 8'h00, 1'b0, "w_addr"));
    vecs.push_back(mk(OP_CHK,   8'h00, 8'h00, 1'b1, "w_busy_on"));
    vecs.push_back(mk(OP_WR,    8'h10, 8'h00, 1'b0, "w_ptr"));
    vecs.push_back(mk(OP_WR,    8'h5A, 8'h00, 1'b0, "w_d0"));
    vecs.push_back(mk(OP_WR,    8'h3C, 8'h00, 1'b0, "w_d1"));
    vecs.push_back(mk(OP_STOP,  8'h00, 8'h00, 1'b0, "w_stop"));
    vecs.push_back(mk(OP_CHK,   8'h12, 8'h00, 1'b0, "w_final"));
    vecs.push_back(mk(OP_WEV,   8'h10, 8'h5A, 1'b0, "w_ev0"));
    vecs.push_back(mk(OP_WEV,   8'h11, 8'h3C, 1'b0, "w_ev1"));
    vecs.push_back(mk(OP_NOEV,  8'h00, 8'h00, 1'b0, "w_noev"));
    // Read with repeated START
    vecs.push_back(mk(OP_START, 8'h00, 8'h00, 1'b0, "r_start"));
    vecs.push_back(mk(OP_WR,    8'hA0, 8'h00, 1'b0, "r_addr_w"));
    vecs.push_back(mk(OP_WR,    8'h20, 8'h00, 1'b0, "r_ptr"));
    vecs.push_back(mk(OP_START, 8'h00, 8'h00, 1'b0, "r_rstart"));
    vecs.push_back(mk(OP_WR,    8'hA1, 8'h00, 1'b0, "r_addr_r"));
    vecs.push_back(mk(OP_RD,    8'h00, 8'hC3, 1'b0, "r_d0"));
    vecs.push_back(mk(OP_RD,    8'h00, 8'h81, 1'b1, "r_d1"));
    vecs.push_back(mk(OP_CHK,   8'h21, 8'h00, 1'b1, "r_waitstop"));
    vecs.push_back(mk(OP_STOP,  8'h00, 8'h00, 1'b0, "r_stop"));
    vecs.push_back(mk(OP_CHK,   8'h21, 8'h00, 1'b0, "r_final"));
    vecs.push_back(mk(OP_REV,   8'h20, 8'h00, 1'b0, "r_ev0"));
    vecs.push_back(mk(OP_REV,   8'h21, 8'h00, 1'b0, "r_ev1"));
    vecs.push_back(mk(OP_NOEV,  8'h00, 8'h00, 1'b0, "r_noev"));
    // Address mismatch
    vecs.push_back(mk(OP_START, 8'h00, 8'h00, 1'b0, "m_start"));
    vecs.push_back(mk(OP_WR,    8'hA2, 8'h00, 1'b1, "m_addr"));
    vecs.push_back(mk(OP_CHK,   8'h21, 8'h00, 1'b0, "m_idle"));
    vecs.push_back(mk(OP_WR,    8'h10, 8'h00, 1'b1, "m_b1"));
    vecs.push_back(mk(OP_WR,    8'hFF, 8'h00, 1'b1, "m_b2"));
    vecs.push_back(mk(OP_STOP,  8'h00, 8'h00, 1'b0, "m_stop"));
    vecs.push_back(mk(OP_CHK,   8'h21, 8'h00, 1'b0, "m_final"));
    vecs.push_back(mk(OP_NOEV,  8'h00, 8'h00, 1'b0, "m_noev"));
    // Pointer wrap
    vecs.push_back(mk(OP_START, 8'h00, 8'h00, 1'b0, "p_start"));
    vecs.push_back(mk(OP_WR,    8'hA0, 8'h00, 1'b0, "p_addr"));
    vecs.push_back(mk(OP_WR,    8'hFF, 8'h00, 1'b0, "p_ptr"));
    vecs.push_back(mk(OP_WR,    8'h11, 8'h00, 1'b0, "p_d0"));
    vecs.push_back(mk(OP_WR,    8'h22, 8'h00, 1'b0, "p_d1"));
    vecs.push_back(mk(OP_STOP,  8'h00, 8'h00, 1'b0, "p_stop"));
    vecs.push_back(mk(OP_CHK,   8'h01, 8'h00, 1'b0, "p_final"));
    vecs.push_back(mk(OP_WEV,   8'hFF, 8'h11, 1'b0, "p_ev0"));
    vecs.push_back(mk(OP_WEV,   8'h00, 8'h22, 1'b0, "p_ev1"));
    vecs.push_back(mk(OP_NOEV,  8'h00, 8'h00, 1'b0, "p_noev"));

    // Reset state
    #100;
    check("rst_sda",      16'(sda_bus),  16'd1);
    check("rst_reg_addr", 16'(reg_addr), 16'd0);
    check("rst_wr_data",  16'(wr_data),  16'd0);
    check("rst_wr_en",    16'(wr_en),    16'd0);
    check("rst_rd_en",    16'(rd_en),    16'd0);
    check("rst_busy",     16'(busy),     16'd0);
    rst_n = 1'b1;
    #200;

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_START: send_start();
        OP_STOP:  send_stop();
        OP_WR: begin
          write_byte(vecs[i].a, ack);
          check({vecs[i].nm, "_ack"}, 16'(ack), 16'(vecs[i].c));
        end
        OP_RD: begin
          read_byte(vecs[i].c, rdb);
          check({vecs[i].nm, "_data"}, 16'(rdb), 16'(vecs[i].b));
        end
        OP_CHK: begin
          check({vecs[i].nm, "_reg_addr"}, 16'(reg_addr), 16'(vecs[i].a));
          check({vecs[i].nm, "_busy"},     16'(busy),     16'(vecs[i].c));
        end
        OP_WEV: begin
          check({vecs[i].nm, "_present"}, 16'(wq.size() > 0), 16'd1);
          if (wq.size() > 0) begin
            we = wq.pop_front();
            check({vecs[i].nm, "_addr"}, 16'(we.a), 16'(vecs[i].a));
            check({vecs[i].nm, "_data"}, 16'(we.d), 16'(vecs[i].b));
          end
        end
        OP_REV: begin
          check({vecs[i].nm, "_present"}, 16'(rq.size() > 0), 16'd1);
          if (rq.size() > 0) begin
            re = rq.pop_front();
            check({vecs[i].nm, "_addr"}, 16'(re), 16'(vecs[i].a));
          end
        end
        OP_NOEV: begin
          check({vecs[i].nm, "_strobes"}, 16'(wq.size() + rq.size()), 16'd0);
          wq.delete();
          rq.delete();
        end
        default: ;
      endcase
      $display("txn %0d %s reg_addr=%02h busy=%0d", i, vecs[i].nm, reg_addr, busy);
    end

    // Abort mid data byte: STOP after 4 bits must discard the byte
    send_start();
    write_byte(8'hA0, ack); check("ab_addr_ack", 16'(ack), 16'd0);
    write_byte(8'h30, ack); check("ab_ptr_ack",  16'(ack), 16'd0);
    send_bit(1'b1, rb); send_bit(1'b0, rb); send_bit(1'b1, rb); send_bit(1'b0, rb);
    send_stop();
    check("ab_busy",     16'(busy),      16'd0);
    check("ab_reg_addr", 16'(reg_addr),  16'h30);
    check("ab_no_wr",    16'(wq.size()), 16'd0);
    $display("txn abort reg_addr=%02h busy=%0d", reg_addr, busy);

    // Reset during the read address ACK period
    send_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'hA1 >> i) & 8'h01) != 8'h00, rb);
    m_sda = 1'b1; #Q; scl = 1'b1; #(Q/2);
    check("rs_ack_driven", 16'(sda_bus), 16'd0);
    rst_n = 1'b0; #1;
    check("rs_sda",      16'(sda_bus),  16'd1);
    check("rs_busy",     16'(busy),     16'd0);
    check("rs_reg_addr", 16'(reg_addr), 16'd0);
    check("rs_wr_data",  16'(wr_data),  16'd0);
    check("rs_wr_en",    16'(wr_en),    16'd0);
    check("rs_rd_en",    16'(rd_en),    16'd0);
    #(Q/2 - 1); scl = 1'b0; #Q;
    rst_n = 1'b1; #Q;
    send_stop();
    check("rs_no_rd", 16'(rq.size()), 16'd0);
    $display("txn reset reg_addr=%02h busy=%0d", reg_addr, busy);

    // Recovery after reset: single write
    send_start();
    write_byte(8'hA0, ack); check("rc_addr_ack", 16'(ack), 16'd0);
    write_byte(8'h04, ack); check("rc_ptr_ack",  16'(ack), 16'd0);
    write_byte(8'h77, ack); check("rc_d_ack",    16'(ack), 16'd0);
    send_stop();
    check("rc_wr_cnt", 16'(wq.size()), 16'd1);
    if (wq.size() > 0) begin
      we = wq.pop_front();
      check("rc_wr_addr", 16'(we.a), 16'h04);
      check("rc_wr_data", 16'(we.d), 16'h77);
    end
    check("rc_reg_addr", 16'(reg_addr), 16'h05);
    $display("txn recover reg_addr=%02h busy=%0d", reg_addr, busy);

`ifdef I2C_GLITCH_FILTER_EN
    // A 2-clk SDA low pulse is filtered out, so no START is seen.
    @(posedge clk); #1; m_sda = 1'b0;
    repeat (2) @(posedge clk);
    #1; m_sda = 1'b1;
    #Q; scl = 1'b0; #Q;
    write_byte(8'hA0, ack);
    check("gf_short_ack",  16'(ack),  16'd1);
    check("gf_short_busy", 16'(busy), 16'd0);
    send_stop();
    // A 6-clk SDA low pulse is accepted as START.
    @(posedge clk); #1; m_sda = 1'b0;
    repeat (6) @(posedge clk);
    #1; scl = 1'b0; #Q;
    write_byte(8'hA0, ack);
    check("gf_long_ack",  16'(ack),  16'd0);
    check("gf_long_busy", 16'(busy), 16'd1);
    send_stop();
    check("gf_long_idle", 16'(busy), 16'd0);
    $display("txn glitch busy=%0d", busy);
`endif

    check("strobe_overlap", 16'(overlap_cnt), 16'd0);
    check("strobe_width",   16'(wide_cnt),    16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
